// File: rtl/interface_coprocessador.sv
// ----------------------------------------------------------------------------
// interface_coprocessador
//
// Purpose:
//   Host-side front end for the matrix coprocessor. A byte-wide command
//   stream is assembled into the opcode, scalar and the flat A/B operand
//   vectors that drive the coprocessor. Once a frame is complete the block
//   waits one cycle for the coprocessor, captures its result, and streams
//   it back one word at a time. Both streams use valid/ready handshakes.
//
// Frame: opcode, escalar, N*N bytes of A, N*N bytes of B (row-major).
// Response: ops 0..5 -> N*N result elements; op 6 -> determinant;
//           op 7 -> a single zero word with a one-cycle erro pulse.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   in_valid/in_ready      command byte handshake, in_data is the byte
//   out_valid/out_ready    result word handshake, out_data is the word
//   out_last               marks the final word of a response
//   erro                   pulses while the invalid-opcode word is accepted
//   busy                   high whenever the block is not idle
//   operacao, escalar, A, B   registered operands driven to the coprocessor
//   resultado, det            coprocessor outputs sampled in CALC
// ----------------------------------------------------------------------------
module interface_coprocessador #(
    parameter int N = 3,
    parameter int WIDTH = 8,
    localparam int RW = 2*WIDTH+3,
    localparam int DW = 3*WIDTH+1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic                   out_last,
    output logic                   erro,
    output logic                   busy,
    output logic [2:0]             operacao,
    output logic [WIDTH-1:0]       escalar,
    output logic [N*N*WIDTH-1:0]   A,
    output logic [N*N*WIDTH-1:0]   B,
    input  logic [N*N*RW-1:0]      resultado,
    input  logic [DW-1:0]          det
);

    localparam int NN = N*N;
    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST_ELEM = CW'(NN-1);

    typedef enum logic [2:0] {
        OCIOSO,
        ESCALAR,
        CARGA_A,
        CARGA_B,
        CALC,
        ENVIO
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_esc;
    logic [WIDTH-1:0] r_matA [NN];
    logic [WIDTH-1:0] r_matB [NN];
    logic [DW-1:0]    r_res [NN];
    logic [DW-1:0]    r_det;

    logic             w_inXfer;
    logic             w_outXfer;
    logic             w_cntEnd;
    logic [CW-1:0]    w_lastIdx;

    assign w_inXfer  = in_valid && in_ready;
    assign w_outXfer = out_valid && out_ready;
    assign w_cntEnd  = (r_cnt == LAST_ELEM);

    // Opcodes 6 and 7 answer with a single word, everything else returns
    // the whole N*N result matrix.
    assign w_lastIdx = (r_op == 3'd6 || r_op == 3'd7) ? '0 : LAST_ELEM;

    // State register: reset always drops back to idle, discarding any
    // partially received frame or partially sent response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OCIOSO;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: loading states advance on input transfers, CALC
    // lasts exactly one cycle, and ENVIO ends on the final output transfer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            OCIOSO:  if (w_inXfer) w_next = ESCALAR;
            ESCALAR: if (w_inXfer) w_next = CARGA_A;
            CARGA_A: if (w_inXfer && w_cntEnd) w_next = CARGA_B;
            CARGA_B: if (w_inXfer && w_cntEnd) w_next = CALC;
            CALC:    w_next = ENVIO;
            ENVIO:   if (w_outXfer && r_cnt == w_lastIdx) w_next = OCIOSO;
            default: w_next = OCIOSO;
        endcase
    end

    // Output logic: in_ready is held low during the reset cycle so no byte
    // can slip in while the state is being forced. out_data is selected from
    // captured registers via the element counter, which freezes while the
    // host stalls, so the word stays stable without an extra holding register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        erro      = 1'b0;
        busy      = (r_state != OCIOSO);
        case (r_state)
            OCIOSO, ESCALAR, CARGA_A, CARGA_B: begin
                in_ready = !rst;
            end
            ENVIO: begin
                out_valid = 1'b1;
                out_last  = (r_cnt == w_lastIdx);
                if (r_op == 3'd7) begin
                    out_data = '0;
                    erro     = out_ready;
                end else if (r_op == 3'd6) begin
                    out_data = r_det;
                end else begin
                    out_data = r_res[r_cnt];
                end
            end
            default: begin
            end
        endcase
    end

    // Element counter: restarts on entry to each matrix load and to the
    // response, and saturates at the last element index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state &&
                     (w_next == CARGA_A || w_next == CARGA_B || w_next == ENVIO)) begin
            r_cnt <= '0;
        end else if ((((r_state == CARGA_A) || (r_state == CARGA_B)) && w_inXfer) ||
                     ((r_state == ENVIO) && w_outXfer)) begin
            if (!w_cntEnd) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Operand registers: each field only changes on the transfer of its own
    // byte, so the coprocessor sees stable inputs through CALC and ENVIO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_esc <= '0;
            for (int i = 0; i < NN; i++) begin
                r_matA[i] <= '0;
                r_matB[i] <= '0;
            end
        end else if (w_inXfer) begin
            case (r_state)
                OCIOSO:  r_op <= in_data[2:0];
                ESCALAR: r_esc <= in_data;
                CARGA_A: r_matA[r_cnt] <= in_data;
                CARGA_B: r_matB[r_cnt] <= in_data;
                default: begin
                end
            endcase
        end
    end

    // Result capture: at the closing edge of CALC every result element is
    // sign-extended to the output word width, together with the determinant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_det <= '0;
            for (int i = 0; i < NN; i++) begin
                r_res[i] <= '0;
            end
        end else if (r_state == CALC) begin
            r_det <= det;
            for (int i = 0; i < NN; i++) begin
                r_res[i] <= DW'($signed(resultado[i*RW +: RW]));
            end
        end
    end

    // Flatten the operand arrays into the packed buses the coprocessor expects,
    // element i at [i*WIDTH +: WIDTH].
    always_comb begin
        operacao = r_op;
        escalar  = r_esc;
        A = '0;
        B = '0;
        for (int i = 0; i < NN; i++) begin
            A[i*WIDTH +: WIDTH] = r_matA[i];
            B[i*WIDTH +: WIDTH] = r_matB[i];
        end
    end

endmodule
